// File: rtl/phase_sequencer.sv
// Machine-cycle phase sequencer: emits SUB_CYCLES one-hot phase strobes per
// machine cycle under run/step/halt/clear control and counts completed cycles.
module phase_sequencer #(
  parameter int SUB_CYCLES = 13,
  parameter int CYC_W      = 16
) (
  input  logic                          in_CLK,
  input  logic                          in_RST_N,
  input  logic                          in_RUN,
  input  logic                          in_STEP,
  input  logic                          in_HALT,
  input  logic                          in_CLEAR,
  output logic [SUB_CYCLES-1:0]         b_CONTROLLER,
  output logic [$clog2(SUB_CYCLES)-1:0] out_PHASE,
  output logic                          out_CYCLE_END,
  output logic                          out_RUNNING,
  output logic                          out_HALTED,
  output logic [CYC_W-1:0]              out_CYCLE_COUNT
);

  localparam int PW = $clog2(SUB_CYCLES);
  localparam logic [PW-1:0] LAST = PW'(SUB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_HALTED
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [PW-1:0]         phase_nxt;
  logic [CYC_W-1:0]      count_nxt;
  logic [SUB_CYCLES-1:0] ctrl_nxt;
  logic                  active_nxt;
  logic                  step_prev;
  logic                  step_edge;

  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are registered copies of the next-state decode, so every output
  // changes only on the clock edge and never follows an input directly.
  always_comb begin
    step_edge  = in_STEP & ~step_prev;
    state_nxt  = state;
    phase_nxt  = out_PHASE;
    count_nxt  = out_CYCLE_COUNT;
    ctrl_nxt   = '0;
    active_nxt = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (in_CLEAR) begin
          count_nxt = '0;
        end else if (in_RUN) begin
          state_nxt = S_RUN;
          phase_nxt = '0;
        end else if (step_edge) begin
          state_nxt = S_STEP;
          phase_nxt = '0;
        end
      end
      S_RUN, S_STEP: begin
        if (out_PHASE == LAST) begin
          count_nxt = out_CYCLE_COUNT + 1'b1;
          phase_nxt = '0;
          if (in_HALT) begin
            state_nxt = S_HALTED;
          end else if (state == S_STEP || !in_RUN) begin
            state_nxt = S_IDLE;
          end
        end else begin
          phase_nxt = out_PHASE + 1'b1;
        end
      end
      S_HALTED: begin
        if (in_CLEAR) begin
          state_nxt = S_IDLE;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        phase_nxt = '0;
      end
    endcase
    active_nxt = (state_nxt == S_RUN) || (state_nxt == S_STEP);
    for (int unsigned i = 0; i < SUB_CYCLES; i++) begin
      ctrl_nxt[i] = active_nxt && (phase_nxt == PW'(i));
    end
  end

  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      out_PHASE       <= '0;
      out_CYCLE_COUNT <= '0;
      b_CONTROLLER    <= '0;
      out_CYCLE_END   <= 1'b0;
      out_RUNNING     <= 1'b0;
      out_HALTED      <= 1'b0;
      step_prev       <= 1'b0;
    end else begin
      out_PHASE       <= phase_nxt;
      out_CYCLE_COUNT <= count_nxt;
      b_CONTROLLER    <= ctrl_nxt;
      out_CYCLE_END   <= ctrl_nxt[SUB_CYCLES-1];
      out_RUNNING     <= active_nxt;
      out_HALTED      <= (state_nxt == S_HALTED);
      step_prev       <= in_STEP;
    end
  end

endmodule
